// File: rtl/updown_counter_pkg.sv
// Shared constants for the parametrised up/down counter.
// Optional build macro used by the counter family: UPDOWN_COUNTER_WRAP_COUNT_EN.
package updown_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-count / terminal-count calculation for updown_counter_param.
// Overflow detection is done in WIDTH+1 bits. The result itself is formed
// modulo 2^WIDTH, which is exact because every chosen result lies in 0..limit.
module updown_next_calc
  import updown_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  i_count,
  input  logic              i_direction,
  input  logic [STEP_W-1:0] i_step,
  input  logic [WIDTH-1:0]  i_limit,
  input  logic              i_sat_mode,
  output logic [WIDTH-1:0]  o_next_count,
  output logic              o_tc_next
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH:0]   w_lim_ext;
  logic [WIDTH:0]   w_step_ext;
  logic [WIDTH:0]   w_s_ext;
  logic [WIDTH:0]   w_sum_ext;
  logic [WIDTH-1:0] w_s;

  assign w_cnt_ext  = {1'b0, i_count};
  assign w_lim_ext  = {1'b0, i_limit};
  assign w_step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, i_step};
  // The effective step never exceeds the range, so it always fits in WIDTH bits.
  assign w_s_ext    = (w_step_ext > w_lim_ext) ? w_lim_ext : w_step_ext;
  assign w_s        = w_s_ext[WIDTH-1:0];
  assign w_sum_ext  = w_cnt_ext + w_s_ext;

  // Select the next count: out-of-range recovery first, then zero step, then up/down.
  always_comb begin
    o_next_count = i_count;
    o_tc_next    = 1'b0;
    if (i_count > i_limit) begin
      // Limit was lowered below the count: snap back into range.
      o_tc_next    = 1'b1;
      o_next_count = (i_sat_mode == MODE_SAT) ? i_limit : '0;
    end else if (w_s == '0) begin
      o_next_count = i_count;
    end else if (i_direction == DIR_UP) begin
      if (w_sum_ext > w_lim_ext) begin
        o_tc_next    = 1'b1;
        o_next_count = (i_sat_mode == MODE_SAT) ? i_limit
                                                : (i_count + w_s - i_limit - ONE);
      end else begin
        o_next_count = i_count + w_s;
      end
    end else begin
      if (w_s_ext > w_cnt_ext) begin
        o_tc_next    = 1'b1;
        o_next_count = (i_sat_mode == MODE_SAT) ? '0
                                                : (i_count + i_limit + ONE - w_s);
      end else begin
        o_next_count = i_count - w_s;
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: programmable width, step and limit, wrap or
// saturate mode, parallel load and a registered terminal-count flag.
// Optional macro UPDOWN_COUNTER_WRAP_COUNT_EN adds an 8-bit saturating count
// of terminal-count events on port wrap_count.
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              direction,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  counter_out,
  output logic              tc,
  output logic              at_max,
  output logic              at_min
`ifdef UPDOWN_COUNTER_WRAP_COUNT_EN
  ,
  output logic [7:0]        wrap_count
`endif
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [WIDTH-1:0] w_next_count;
  logic             w_tc_next;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_load_clamped = (load_val > limit) ? limit : load_val;

  updown_next_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next_calc (
    .i_count      (r_count),
    .i_direction  (direction),
    .i_step       (step),
    .i_limit      (limit),
    .i_sat_mode   (sat_mode),
    .o_next_count (w_next_count),
    .o_tc_next    (w_tc_next)
  );

  // Count and terminal-count registers with rst > load > enable priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_tc    <= 1'b0;
    end else if (enable) begin
      r_count <= w_next_count;
      r_tc    <= w_tc_next;
    end
  end

`ifdef UPDOWN_COUNTER_WRAP_COUNT_EN
  logic [7:0] r_wrap_count;

  // Count every cycle that sets tc, sticking at 255.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_wrap_count <= '0;
    end else if (enable && w_tc_next && (r_wrap_count != 8'hFF)) begin
      r_wrap_count <= r_wrap_count + 8'd1;
    end
  end

  assign wrap_count = r_wrap_count;
`endif

  assign counter_out = r_count;
  assign tc          = r_tc;
  assign at_max      = (r_count >= limit);
  assign at_min      = (r_count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              direction;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic              sat_mode;
  logic [WIDTH-1:0]  counter_out;
  logic              tc;
  logic              at_max;
  logic              at_min;
`ifdef UPDOWN_COUNTER_WRAP_COUNT_EN
  logic [7:0]        wrap_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  updown_counter_param #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .direction   (direction),
    .load        (load),
    .load_val    (load_val),
    .step        (step),
    .limit       (limit),
    .sat_mode    (sat_mode),
    .counter_out (counter_out),
    .tc          (tc),
    .at_max      (at_max),
    .at_min      (at_min)
`ifdef UPDOWN_COUNTER_WRAP_COUNT_EN
    ,
    .wrap_count  (wrap_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the range 0..limit.
  int m_cnt = 0;
  int m_tc  = 0;
  int m_wc  = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int lim, s, c;
    lim = int'(limit);
    c   = m_cnt;
    if (rst) begin
      m_cnt = 0; m_tc = 0; m_wc = 0; m_valid = 1'b1;
    end else if (load) begin
      m_cnt = (int'(load_val) < lim) ? int'(load_val) : lim;
      m_tc  = 0; m_wc = 0;
    end else if (enable) begin
      s = (int'(step) < lim) ? int'(step) : lim;
      if (c > lim) begin
        m_cnt = sat_mode ? lim : 0; m_tc = 1;
      end else if (s == 0) begin
        m_tc = 0;
      end else if (direction) begin
        if (c + s > lim) begin
          m_cnt = sat_mode ? lim : (c + s) % (lim + 1); m_tc = 1;
        end else begin
          m_cnt = c + s; m_tc = 0;
        end
      end else begin
        if (c - s < 0) begin
          m_cnt = sat_mode ? 0 : (c - s + lim + 1); m_tc = 1;
        end else begin
          m_cnt = c - s; m_tc = 0;
        end
      end
      if (m_tc == 1 && m_wc < 255) m_wc++;
    end
  end

  // Compare DUT against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_count", 32'(counter_out), 32'(m_cnt));
      chk("model_tc", 32'(tc), 32'(m_tc));
      chk("model_at_max", 32'(at_max), 32'(m_cnt >= int'(limit)));
      chk("model_at_min", 32'(at_min), 32'(m_cnt == 0));
`ifdef UPDOWN_COUNTER_WRAP_COUNT_EN
      chk("model_wrap_count", 32'(wrap_count), 32'(m_wc));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ct(input string nm, input int cnt, input int t);
    chk({nm, "_count"}, 32'(counter_out), 32'(cnt));
    chk({nm, "_tc"}, 32'(tc), 32'(t));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; direction = 1'b1; load = 1'b0; load_val = '0;
    step = 4'd1; limit = 8'd255; sat_mode = 1'b0;

    // 1: reset then free-running up count
    tick(); tick();
    expect_ct("reset", 0, 0);
    chk("reset_at_min", 32'(at_min), 32'd1);
    rst = 1'b0; enable = 1'b1;
    tick(); expect_ct("up1", 1, 0);
    tick(); expect_ct("up2", 2, 0);
    tick(); expect_ct("up3", 3, 0);

    // 2: wrap within 0..9, step 3
    limit = 8'd9; step = 4'd3; load = 1'b1; load_val = 8'd8;
    tick(); expect_ct("wrap_load", 8, 0);
    load = 1'b0;
    tick(); expect_ct("wrap_over", 1, 1);
    tick(); expect_ct("wrap_after", 4, 0);

    // 3: saturate at 200
    sat_mode = 1'b1; limit = 8'd200; step = 4'd5; load = 1'b1; load_val = 8'd198;
    tick(); expect_ct("sat_load", 198, 0);
    load = 1'b0;
    tick(); expect_ct("sat_hit", 200, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_ct("sat_pinned", 200, 1);
    end
    chk("sat_at_max", 32'(at_max), 32'd1);
    direction = 1'b0;
    tick(); expect_ct("sat_reverse", 195, 0);

    // 4: full-range down wrap from 0
    sat_mode = 1'b0; limit = 8'd255; step = 4'd1; load = 1'b1; load_val = 8'd0;
    tick(); expect_ct("dn_load", 0, 0);
    load = 1'b0;
    tick(); expect_ct("dn_wrap", 255, 1);
    tick(); expect_ct("dn_after", 254, 0);

    // 5: hold while disabled, then load clamps to limit
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      direction = ~direction; step = 4'(i * 3 + 2);
      tick(); expect_ct("hold", 254, 0);
    end
    load = 1'b1; load_val = 8'd50; limit = 8'd20;
    tick(); expect_ct("load_clamp", 20, 0);
    chk("load_clamp_at_max", 32'(at_max), 32'd1);
    load = 1'b0;

    // Out-of-range recovery, pinned at zero, oversized step, zero step
    enable = 1'b1; limit = 8'd10; sat_mode = 1'b0; direction = 1'b1; step = 4'd1;
    tick(); expect_ct("oor_wrap", 0, 1);
    sat_mode = 1'b1; direction = 1'b0; step = 4'd3;
    tick(); expect_ct("sat_zero", 0, 1);
    sat_mode = 1'b0; limit = 8'd5; step = 4'd7;
    tick(); expect_ct("big_step_wrap", 1, 1);
`ifdef UPDOWN_COUNTER_WRAP_COUNT_EN
    chk("wrap_count_3", 32'(wrap_count), 32'd3);
`endif
    step = 4'd0;
    tick(); expect_ct("zero_step", 1, 0);

    // 6: reset wins over load and enable
    limit = 8'd255; load = 1'b1; load_val = 8'd7; enable = 1'b0;
    tick(); expect_ct("pre_rst_load", 7, 0);
    rst = 1'b1; load = 1'b1; enable = 1'b1; step = 4'd1;
    tick(); expect_ct("rst_prio", 0, 0);
    chk("rst_prio_at_min", 32'(at_min), 32'd1);
`ifdef UPDOWN_COUNTER_WRAP_COUNT_EN
    chk("rst_wrap_count", 32'(wrap_count), 32'd0);
`endif
    rst = 1'b0; load = 1'b0;

    // Mixed traffic checked against the model only
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      load      = ($urandom_range(0, 99) < 8);
      enable    = ($urandom_range(0, 99) < 80);
      direction = 1'($urandom_range(0, 1));
      sat_mode  = 1'($urandom_range(0, 1));
      step      = 4'($urandom_range(0, 15));
      load_val  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 2) limit = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 9) < 3) limit = 8'($urandom_range(0, 12));
      tick();
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
